seq_divider32: RTL and testbench



---
 rtl/seq_divider32.sv | 114 +++++++++++
 tb/tb_seq_divider32.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider32.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, start/done handshake.
// Q, R and div_by_zero update only when an operation completes and hold until the next one does.
module seq_divider32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] N,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CntInit = CW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state, w_state_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quo, r_div, r_rem;
  logic [WIDTH-1:0] r_q, r_r;
  logic             r_dbz;

  logic [WIDTH-1:0] w_rem_sh, w_rem_next, w_quo_next;
  logic [WIDTH:0]   w_trial;
  logic             w_borrow;

  // One restoring step: shift in the next dividend bit, keep the difference if no borrow.
  always_comb begin
    w_rem_sh   = {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
    w_trial    = {1'b0, w_rem_sh} - {1'b0, r_div};
    w_borrow   = w_trial[WIDTH];
    w_rem_next = w_borrow ? w_rem_sh : w_trial[WIDTH-1:0];
    w_quo_next = {r_quo[WIDTH-2:0], ~w_borrow};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_next = (D == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (r_cnt == '0) begin
          w_state_next = StDone;
        end
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_quo <= '0;
      r_div <= '0;
      r_rem <= '0;
      r_q   <= '0;
      r_r   <= '0;
      r_dbz <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_quo <= N;
            r_div <= D;
            r_rem <= '0;
            if (D == '0) begin
              r_q   <= '1;
              r_r   <= N;
              r_dbz <= 1'b1;
            end else begin
              r_cnt <= CntInit;
            end
          end
        end
        StRun: begin
          r_quo <= w_quo_next;
          r_rem <= w_rem_next;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_q   <= w_quo_next;
            r_r   <= w_rem_next;
            r_dbz <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != StIdle);
  assign done        = (r_state == StDone);
  assign Q           = r_q;
  assign R           = r_r;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider32.sv
// Self-checking bench for seq_divider32: vector table, handshake corner cases and random ops
// checked against a plain-arithmetic division model.
module tb_seq_divider32;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] n_in, d_in;
  logic [31:0] q_out, r_out;
  logic        busy, done, dbz;

  int n_checks = 0;
  int n_errors = 0;

  seq_divider32 #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .N          (n_in),
    .D          (d_in),
    .Q          (q_out),
    .R          (r_out),
    .busy       (busy),
    .done       (done),
    .div_by_zero(dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] n, d, q, r;
    logic        z;
    int          busy_cycles;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: straight arithmetic, all-ones/N on a zero divisor.
  task automatic model(input logic [31:0] n, input logic [31:0] d,
                       output logic [31:0] q, output logic [31:0] r, output logic z);
    if (d == 0) begin
      q = 32'hFFFF_FFFF;
      r = n;
      z = 1'b1;
    end else begin
      q = n / d;
      r = n % d;
      z = 1'b0;
    end
  endtask

  // Issue one operation from IDLE and wait (bounded) for its done pulse.
  task automatic run_op(input logic [31:0] n, input logic [31:0] d,
                        output logic [31:0] q, output logic [31:0] r, output logic z,
                        output int bc);
    bit got;
    got = 0;
    bc  = 0;
    q   = '0;
    r   = '0;
    z   = 1'b0;
    n_in  = n;
    d_in  = d;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      if (busy) bc++;
      if (done) begin
        got = 1;
        q = q_out;
        r = r_out;
        z = dbz;
      end else begin
        tick();
      end
    end
    check("done_seen", 32'(got), 32'd1);
    tick();
    check("done_one_cycle", {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    vec_t        vecs[8];
    logic [31:0] q, r, eq, er;
    logic        z, ez;
    int          bc;
    int          ndone;
    logic [31:0] pn[4], pd[4];
    int          idx, last;

    vecs[0] = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33};
    vecs[1] = '{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33};
    vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 33};
    vecs[3] = '{32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1};
    vecs[4] = '{32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33};
    vecs[5] = '{32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 33};
    vecs[6] = '{32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 33};
    vecs[7] = '{32'h8000_0000, 32'h8000_0001, 32'd0, 32'h8000_0000, 1'b0, 33};

    rst   = 1'b1;
    start = 1'b0;
    n_in  = '0;
    d_in  = '0;
    tick();
    tick();
    check("rst_q", q_out, 32'd0);
    check("rst_r", r_out, 32'd0);
    check("rst_flags", {29'd0, busy, done, dbz}, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].n, vecs[i].d, q, r, z, bc);
      check($sformatf("vec%0d_q", i), q, vecs[i].q);
      check($sformatf("vec%0d_r", i), r, vecs[i].r);
      check($sformatf("vec%0d_dbz", i), 32'(z), 32'(vecs[i].z));
      check($sformatf("vec%0d_busy", i), bc, vecs[i].busy_cycles);
    end

    // Divide-by-zero result must hold through the whole following RUN.
    run_op(32'd5, 32'd0, q, r, z, bc);
    n_in  = 32'd9;
    d_in  = 32'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_in  = 32'd77;
    d_in  = 32'd0;
    repeat (5) tick();
    check("hold_q", q_out, 32'hFFFF_FFFF);
    check("hold_r", r_out, 32'd5);
    check("hold_dbz", 32'(dbz), 32'd1);
    for (int k = 0; k < 100 && !done; k++) tick();
    check("after_dbz_q", q_out, 32'd3);
    check("after_dbz_r", r_out, 32'd0);
    check("after_dbz_dbz", 32'(dbz), 32'd0);
    tick();

    // Start re-pulsed mid-operation is ignored.
    n_in  = 32'd3;
    d_in  = 32'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    n_in  = 32'd50;
    d_in  = 32'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    q = '0;
    r = '0;
    for (int k = 0; k < 70; k++) begin
      if (done) begin
        ndone++;
        q = q_out;
        r = r_out;
      end
      tick();
    end
    check("repulse_ndone", ndone, 32'd1);
    check("repulse_q", q, 32'd0);
    check("repulse_r", r, 32'd3);

    // Reset mid-operation aborts immediately.
    run_op(32'd100, 32'd7, q, r, z, bc);
    n_in  = 32'd1000;
    d_in  = 32'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (16) tick();
    rst = 1'b1;
    #1;
    check("abort_q", q_out, 32'd0);
    check("abort_r", r_out, 32'd0);
    check("abort_flags", {29'd0, busy, done, dbz}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    run_op(32'd1000, 32'd3, q, r, z, bc);
    check("post_rst_q", q, 32'd333);
    check("post_rst_r", r, 32'd1);

    // start held high: back-to-back ops, operands swapped at each done.
    for (int i = 0; i < 4; i++) begin
      pn[i] = $urandom;
      pd[i] = ($urandom >> $urandom_range(0, 31)) | 32'd1;
    end
    idx   = 0;
    last  = 0;
    n_in  = pn[0];
    d_in  = pd[0];
    start = 1'b1;
    for (int c = 0; c < 400 && idx < 4; c++) begin
      tick();
      if (done) begin
        model(pn[idx], pd[idx], eq, er, ez);
        check($sformatf("b2b%0d_q", idx), q_out, eq);
        check($sformatf("b2b%0d_r", idx), r_out, er);
        if (idx > 0) check("b2b_gap", c - last, 32'd34);
        last = c;
        idx++;
        if (idx < 4) begin
          n_in = pn[idx];
          d_in = pd[idx];
        end
      end
    end
    start = 1'b0;
    check("b2b_count", idx, 32'd4);
    repeat (3) tick();

    for (int i = 0; i < 1000; i++) begin
      logic [31:0] rn, rd;
      rn = $urandom >> $urandom_range(0, 31);
      rd = ($urandom_range(0, 49) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      model(rn, rd, eq, er, ez);
      run_op(rn, rd, q, r, z, bc);
      check("rnd_q", q, eq);
      check("rnd_r", r, er);
      check("rnd_dbz", 32'(z), 32'(ez));
      if (rd != 0) begin
        check("rnd_inv", 32'((64'(q) * 64'(rd) + 64'(r) == 64'(rn)) && (r < rd)), 32'd1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
